mem_bus: RTL
============

// Module: mem_bus
// PURPOSE
//  Memory-side slave for the cpu native bus (mem_valid/mem_ready/mem_addr/mem_rdata/mem_wdata/mem_wstrb).
//  Decodes each request to: on-chip word RAM (program + data, holds RESET_PC image), MMIO page
//  (GPIO out, UART TX handshake port, TX status, free-running cycle counter), or unmapped (error).
//  Sits directly downstream of cpu; one outstanding transaction, single-cycle mem_ready pulse per request.
// PARAMETERS
//  RAM_BASE   32'h01000000  byte base of RAM window (word-aligned)
//  RAM_WORDS  4096          RAM depth in 32-bit words (power of 2)
//  MMIO_BASE  32'h02000000  byte base of 256-byte MMIO page
//  GPIO_W     8             width of gpio_out
//  INIT_FILE  ""            hex image loaded into RAM via $readmemh when non-empty
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous, active-high reset
//  mem_valid  in   1        request valid; held by master until mem_ready seen
//  mem_ready  out  1        one-cycle pulse: request complete, mem_rdata valid for reads
//  mem_addr   in   32       byte address; bits [1:0] ignored
//  mem_rdata  out  32       read data, valid in mem_ready cycle
//  mem_wdata  in   32       write data, byte lanes per mem_wstrb
//  mem_wstrb  in   4        byte strobes; 4'b0000 = read, non-zero = write
//  gpio_out   out  GPIO_W   GPIO output register
//  tx_valid   out  1        UART TX byte pending
//  tx_data    out  8        UART TX byte, stable while tx_valid
//  tx_ready   in   1        UART accepts byte when tx_valid && tx_ready
//  bus_err    out  1        sticky: an unmapped access occurred
// BEHAVIOUR
//  Reset: state=IDLE, mem_ready=0, mem_rdata=0, gpio_out=0, tx_valid=0, tx_data=0, bus_err=0, cycle counter=0.
//   RAM contents not cleared. Reset mid-transaction aborts it: no ready, pending write not performed.
//  FSM states: IDLE, RAM_RD, RESP, TX_WAIT.
//  IDLE: mem_valid=1 accepts request at that edge; decode on mem_addr:
//   RAM hit (mem_addr - RAM_BASE < RAM_WORDS*4, unsigned): read -> RAM_RD; write -> perform byte-lane
//    write at accept edge, -> RESP.
//   MMIO +0x0 GPIO: write lane0 -> gpio_out (if wstrb[0]); read -> zero-extended gpio_out. -> RESP.
//   MMIO +0x4 TXDATA: write with wstrb[0]: tx_valid=0 -> load tx_data=wdata[7:0], tx_valid<=1, -> RESP;
//    tx_valid=1 -> TX_WAIT. Read returns 0.
//   MMIO +0x8 TXSTAT: read {31'b0, tx_valid}; write ignored. -> RESP.
//   MMIO +0xC CYCLES: read counter value at accept edge; write ignored. -> RESP.
//   Anything else: read data 32'hDEADBEEF, write dropped, bus_err<=1. -> RESP.
//  RAM_RD: synchronous RAM word read registered -> mem_rdata; -> RESP.
//  TX_WAIT: when tx_ready (old byte accepted) load new byte, tx_valid stays 1, -> RESP. Master stalls meanwhile.
//  RESP: mem_ready=1 for exactly this cycle; mem_valid ignored; -> IDLE. mem_ready low in all other states.
//  Latency (accept edge to mem_ready high): RAM read 2 cycles; all others 1 cycle; TXDATA stall +N.
//  Request must stay stable while mem_valid high; controller samples addr/wdata/wstrb only at accept.
//  Back-to-back: new valid in the cycle after RESP is accepted immediately (no dead cycle).
//  tx handshake: tx_valid drops the cycle after tx_valid && tx_ready unless a new byte loads same edge.
//  mem_rdata holds last value outside RESP; write responses leave mem_rdata unchanged.
//  Cycle counter: 32-bit, +1 every cycle after reset, wraps 32'hFFFFFFFF -> 0.
//  Partial writes: only lanes with wstrb[i]=1 change; RAM addressed by (mem_addr - RAM_BASE) >> 2.
// TESTING
//  Write 32'hCAFEBABE @0x01000010 wstrb=1111, read back -> ready 1 cycle after write accept, read rdata=CAFEBABE 2 cycles after accept.
//  wstrb=0100 wdata=32'h00AA0000 over CAFEBABE -> read 32'hCAAABABE; ready pulses exactly 1 cycle each.
//  Read 0x03000000 -> rdata=DEADBEEF, ready 1 cycle after accept, bus_err=1 and stays 1 until rst.
//  Two TXDATA writes 0x41,0x42 with tx_ready=0 -> second stalls; raise tx_ready -> 0x41 out, ready, then 0x42 pending.
//  GPIO write 0x5A then rst asserted mid RAM read -> gpio_out=0, mem_ready never pulses, FSM IDLE.
//  Read CYCLES twice, 10 cycles apart -> difference 10; force wrap past FFFFFFFF -> reads small value.

Source files
------------

// File: rtl/mem_bus_if.sv
// mem_bus_if: cpu native memory bus, one outstanding transaction.
//   mem_valid  master -> slave  request valid, held until mem_ready
//   mem_ready  slave -> master  one-cycle completion pulse
//   mem_addr   master -> slave  byte address
//   mem_rdata  slave -> master  read data, valid while mem_ready is high
//   mem_wdata  master -> slave  write data
//   mem_wstrb  master -> slave  byte strobes, 4'b0000 means read
interface mem_bus_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_bus.sv
// mem_bus: memory-side slave for the cpu native bus. Decodes each request to the on-chip
// word RAM, the MMIO page (GPIO, UART TX data/status, cycle counter) or unmapped space.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        mem_bus_if slave port (valid/ready/addr/rdata/wdata/wstrb)
//   gpio_out   GPIO output register
//   tx_valid   UART TX byte pending
//   tx_data    UART TX byte, stable while tx_valid
//   tx_ready   UART accepts the byte when tx_valid && tx_ready
//   bus_err    sticky flag: an unmapped access occurred
module mem_bus #(
    parameter logic [31:0] RAM_BASE  = 32'h0100_0000,
    parameter int unsigned RAM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h0200_0000,
    parameter int unsigned GPIO_W    = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_if.slave          bus,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              bus_err
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    typedef enum logic [1:0] {StIdle, StRamRd, StResp, StTxWait} state_e;

    state_e            state_q, state_d;
    logic [31:0]       rdata_q;
    logic [GPIO_W-1:0] gpio_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic [7:0]        tx_pend_q;
    logic              bus_err_q;
    logic [31:0]       cycle_q;
    logic [AW-1:0]     ram_idx_q;

    logic [31:0] mem [RAM_WORDS];

    // Address decode, only meaningful in StIdle while mem_valid is high.
    logic [31:0]   ram_off;
    logic [AW-1:0] ram_widx;
    logic          hit_ram, mmio_page, hit_gpio, hit_txdata, hit_txstat, hit_cycles;
    logic          is_write, accept, ram_we, tx_free;

    // Unsigned subtract folds the below-base case into the single range compare.
    assign ram_off    = bus.mem_addr - RAM_BASE;
    assign ram_widx   = ram_off[AW+1:2];
    assign hit_ram    = ram_off < RAM_BYTES;
    assign mmio_page  = bus.mem_addr[31:8] == MMIO_BASE[31:8];
    assign hit_gpio   = !hit_ram && mmio_page && (bus.mem_addr[7:2] == 6'd0);
    assign hit_txdata = !hit_ram && mmio_page && (bus.mem_addr[7:2] == 6'd1);
    assign hit_txstat = !hit_ram && mmio_page && (bus.mem_addr[7:2] == 6'd2);
    assign hit_cycles = !hit_ram && mmio_page && (bus.mem_addr[7:2] == 6'd3);
    assign is_write   = |bus.mem_wstrb;
    assign accept     = (state_q == StIdle) && bus.mem_valid;
    // A write accepted on a reset edge must not reach the RAM.
    assign ram_we     = !rst && accept && hit_ram && is_write;
    // The holding register is free once the old byte is gone or leaves this edge.
    assign tx_free    = !tx_valid_q || tx_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_valid) begin
                    if (hit_ram && !is_write) begin
                        state_d = StRamRd;
                    end else if (hit_txdata && bus.mem_wstrb[0] && tx_valid_q) begin
                        state_d = StTxWait;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StRamRd:  state_d = StResp;
            StTxWait: if (tx_free) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.mem_ready = (state_q == StResp);
        bus.mem_rdata = rdata_q;
        gpio_out      = gpio_q;
        tx_valid      = tx_valid_q;
        tx_data       = tx_data_q;
        bus_err       = bus_err_q;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= 32'd0;
            gpio_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_pend_q  <= 8'd0;
            bus_err_q  <= 1'b0;
            cycle_q    <= 32'd0;
            ram_idx_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            // Handshake drop; a byte loaded below on the same edge overrides it.
            if (tx_valid_q && tx_ready) begin
                tx_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.mem_valid) begin
                        if (hit_ram) begin
                            ram_idx_q <= ram_widx;
                        end else if (hit_gpio) begin
                            if (!is_write) begin
                                rdata_q <= 32'(gpio_q);
                            end else if (bus.mem_wstrb[0]) begin
                                gpio_q <= GPIO_W'(bus.mem_wdata[7:0]);
                            end
                        end else if (hit_txdata) begin
                            if (!is_write) begin
                                rdata_q <= 32'd0;
                            end else if (bus.mem_wstrb[0]) begin
                                if (!tx_valid_q) begin
                                    tx_data_q  <= bus.mem_wdata[7:0];
                                    tx_valid_q <= 1'b1;
                                end else begin
                                    tx_pend_q <= bus.mem_wdata[7:0];
                                end
                            end
                        end else if (hit_txstat) begin
                            if (!is_write) rdata_q <= {31'd0, tx_valid_q};
                        end else if (hit_cycles) begin
                            if (!is_write) rdata_q <= cycle_q;
                        end else begin
                            bus_err_q <= 1'b1;
                            if (!is_write) rdata_q <= 32'hDEAD_BEEF;
                        end
                    end
                end
                StRamRd: rdata_q <= mem[ram_idx_q];
                StTxWait: begin
                    if (tx_free) begin
                        tx_data_q  <= tx_pend_q;
                        tx_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM write port: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_wstrb[i]) begin
                    mem[ram_widx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
